// File: rtl/matrix_link_receiver_pkg.sv
// Shared types and width helpers for the matrix link receiver.
// Optional statistics counters are enabled by defining MATRIX_RX_STATS_EN.
package matrix_link_pkg;

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } rx_state_t;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    localparam int unsigned BIT_CNT_W  = $clog2(8 + 1);
    localparam int unsigned IDLE_CNT_W = $clog2(64 + 1);

endpackage

// File: rtl/matrix_link_receiver_if.sv
// Word-delivery handshake between the receiver (master) and its consumer (slave).
interface matrix_link_receiver_if #(
    parameter int unsigned CHANNEL_NUMBER = 3,
    parameter int unsigned SPI_SIZE       = 8
);

    logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] data_out;
    logic                                    data_valid;
    logic                                    data_ready;
    logic                                    overrun;
    logic                                    sync_error;

    modport master (
        output data_out,
        output data_valid,
        output overrun,
        output sync_error,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  overrun,
        input  sync_error,
        output data_ready
    );

endinterface

// File: rtl/matrix_link_receiver_link_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin with a registered rising-edge pulse.
module link_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;
    logic                   r_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_dly  <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_dly;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/matrix_link_receiver.sv
// Loopback receiver: deserialises parallel SPI MOSI lanes and decodes a 595-style column stream.
// Define MATRIX_RX_STATS_EN to add word/error/column statistics counters.
module matrix_link_receiver
    import matrix_link_pkg::*;
#(
    parameter int unsigned CHANNEL_NUMBER = 3,
    parameter int unsigned SPI_SIZE       = 8,
    parameter bit          MSB_FIRST      = 1'b1,
    parameter int unsigned COLUMN_BITS    = 16,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           spi_clk,
    input  logic [CHANNEL_NUMBER-1:0]      spi_mosi,
    input  logic                           ser_clk,
    input  logic                           ser_data,
    input  logic                           ser_stcp,
    input  logic                           ser_n_enable,
    matrix_link_receiver_if.master         rx_if,
    output logic [COLUMN_BITS-1:0]         column_out,
    output logic [$clog2(COLUMN_BITS)-1:0] column_index,
    output logic                           column_onehot,
    output logic                           column_valid,
    output logic                           output_enabled
`ifdef MATRIX_RX_STATS_EN
    ,
    output logic [31:0]                    word_count,
    output logic [15:0]                    error_count,
    output logic [15:0]                    column_count
`endif
);

    localparam int unsigned BitCntW  = cnt_width(SPI_SIZE);
    localparam int unsigned IdleCntW = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned IdxW     = $clog2(COLUMN_BITS);
    localparam int unsigned PipeW    = CHANNEL_NUMBER + 2;

    typedef logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] word_t;

    // Level synchronisers one stage longer than the edge synchronisers' sync chain so every
    // sampled level lines up with the registered rise pulses.
    logic [PipeW-1:0] r_pipe [SYNC_STAGES+1];

    logic [CHANNEL_NUMBER-1:0] w_mosi;
    logic                      w_ser_data;
    logic                      w_spi_rise;
    logic                      w_sclk_rise;
    logic                      w_stcp_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= SYNC_STAGES; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= {~ser_n_enable, ser_data, spi_mosi};
            for (int i = 1; i <= SYNC_STAGES; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_mosi         = r_pipe[SYNC_STAGES][CHANNEL_NUMBER-1:0];
    assign w_ser_data     = r_pipe[SYNC_STAGES][CHANNEL_NUMBER];
    assign output_enabled = r_pipe[SYNC_STAGES][CHANNEL_NUMBER+1];

    link_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_spi_clk (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(spi_clk),
        .o_rise (w_spi_rise)
    );

    link_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ser_clk (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(ser_clk),
        .o_rise (w_sclk_rise)
    );

    link_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ser_stcp (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(ser_stcp),
        .o_rise (w_stcp_rise)
    );

    rx_state_t             r_state;
    logic [BitCntW-1:0]    r_bit_cnt;
    logic [IdleCntW-1:0]   r_idle_cnt;
    word_t                 r_shift;
    word_t                 w_shift_nxt;
    word_t                 r_data;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  r_sync_error;
    logic                  w_done;
    logic                  w_timeout;
    logic                  w_overrun_evt;

    always_comb begin
        w_shift_nxt = r_shift;
        for (int c = 0; c < CHANNEL_NUMBER; c++) begin
            if (MSB_FIRST) begin
                w_shift_nxt[c] = {r_shift[c][SPI_SIZE-2:0], w_mosi[c]};
            end else begin
                w_shift_nxt[c] = {w_mosi[c], r_shift[c][SPI_SIZE-1:1]};
            end
        end
    end

    assign w_done        = (r_state == RX_SHIFT) && w_spi_rise &&
                           (r_bit_cnt == BitCntW'(SPI_SIZE - 1));
    assign w_timeout     = (r_state == RX_SHIFT) && !w_spi_rise &&
                           (r_idle_cnt == IdleCntW'(TIMEOUT_CYCLES - 1));
    assign w_overrun_evt = w_done && r_valid && !rx_if.data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RX_IDLE;
            r_bit_cnt    <= '0;
            r_idle_cnt   <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
            r_sync_error <= 1'b0;
        end else begin
            r_sync_error <= 1'b0;

            if (w_spi_rise) begin
                r_idle_cnt <= '0;
                r_shift    <= w_shift_nxt;
            end else if (r_idle_cnt != IdleCntW'(TIMEOUT_CYCLES)) begin
                r_idle_cnt <= r_idle_cnt + IdleCntW'(1);
            end

            case (r_state)
                RX_IDLE: begin
                    if (w_spi_rise) begin
                        r_state   <= RX_SHIFT;
                        r_bit_cnt <= BitCntW'(1);
                    end
                end
                RX_SHIFT: begin
                    if (w_done) begin
                        r_state   <= RX_IDLE;
                        r_bit_cnt <= '0;
                    end else if (w_spi_rise) begin
                        r_bit_cnt <= r_bit_cnt + BitCntW'(1);
                    end else if (w_timeout) begin
                        r_state      <= RX_IDLE;
                        r_bit_cnt    <= '0;
                        r_shift      <= '0;
                        r_sync_error <= 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase

            // A completion always wins over a transfer so the newest word is never dropped.
            if (w_done) begin
                r_data  <= w_shift_nxt;
                r_valid <= 1'b1;
                if (w_overrun_evt) r_overrun <= 1'b1;
            end else if (r_valid && rx_if.data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_if.data_out   = r_data;
    assign rx_if.data_valid = r_valid;
    assign rx_if.overrun    = r_overrun;
    assign rx_if.sync_error = r_sync_error;

    logic [COLUMN_BITS-1:0] r_colshift;
    logic [COLUMN_BITS-1:0] r_column;
    logic                   r_col_valid;
    logic [IdxW-1:0]        w_col_index;

    // Latching reads the pre-shift register when both clocks rise together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_colshift  <= '0;
            r_column    <= '0;
            r_col_valid <= 1'b0;
        end else begin
            if (w_sclk_rise) r_colshift <= {r_colshift[COLUMN_BITS-2:0], w_ser_data};
            if (w_stcp_rise) r_column <= r_colshift;
            r_col_valid <= w_stcp_rise;
        end
    end

    always_comb begin
        w_col_index = '0;
        for (int i = COLUMN_BITS - 1; i >= 0; i--) begin
            if (r_column[i]) w_col_index = IdxW'(i);
        end
    end

    assign column_out    = r_column;
    assign column_index  = w_col_index;
    assign column_onehot = $onehot(r_column);
    assign column_valid  = r_col_valid;

`ifdef MATRIX_RX_STATS_EN
    logic [31:0] r_word_cnt;
    logic [15:0] r_err_cnt;
    logic [15:0] r_col_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
            r_col_cnt  <= '0;
        end else begin
            if (w_done) r_word_cnt <= r_word_cnt + 32'd1;
            if (w_overrun_evt || w_timeout) r_err_cnt <= r_err_cnt + 16'd1;
            if (w_stcp_rise) r_col_cnt <= r_col_cnt + 16'd1;
        end
    end

    assign word_count   = r_word_cnt;
    assign error_count  = r_err_cnt;
    assign column_count = r_col_cnt;
`endif

endmodule

// File: tb/tb_matrix_link_receiver.sv
// Scoreboard bench for matrix_link_receiver: pin-level stimulus, queue-based expected words/columns.
module tb_matrix_link_receiver;

    localparam int unsigned CH  = 3;
    localparam int unsigned SZ  = 8;
    localparam bit          MSB = 1'b1;
    localparam int unsigned CB  = 16;
    localparam int unsigned SS  = 2;
    localparam int unsigned TO  = 64;

    typedef logic [CH-1:0][SZ-1:0] word_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  spi_clk = 1'b0;
    logic [CH-1:0]         spi_mosi = '0;
    logic                  ser_clk = 1'b0;
    logic                  ser_data = 1'b0;
    logic                  ser_stcp = 1'b0;
    logic                  ser_n_enable = 1'b1;
    logic [CB-1:0]         column_out;
    logic [$clog2(CB)-1:0] column_index;
    logic                  column_onehot;
    logic                  column_valid;
    logic                  output_enabled;
`ifdef MATRIX_RX_STATS_EN
    logic [31:0]           word_count;
    logic [15:0]           error_count;
    logic [15:0]           column_count;
`endif

    matrix_link_receiver_if #(.CHANNEL_NUMBER(CH), .SPI_SIZE(SZ)) u_if ();

    matrix_link_receiver #(
        .CHANNEL_NUMBER(CH),
        .SPI_SIZE      (SZ),
        .MSB_FIRST     (MSB),
        .COLUMN_BITS   (CB),
        .SYNC_STAGES   (SS),
        .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .ser_clk       (ser_clk),
        .ser_data      (ser_data),
        .ser_stcp      (ser_stcp),
        .ser_n_enable  (ser_n_enable),
        .rx_if         (u_if),
        .column_out    (column_out),
        .column_index  (column_index),
        .column_onehot (column_onehot),
        .column_valid  (column_valid),
        .output_enabled(output_enabled)
`ifdef MATRIX_RX_STATS_EN
        ,
        .word_count    (word_count),
        .error_count   (error_count),
        .column_count  (column_count)
`endif
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_fail = 0;
    word_t         exp_q[$];
    logic [CB-1:0] col_q[$];
    logic [CB-1:0] col_model = '0;
    bit            exp_overrun = 1'b0;
    int            exp_sync_err = 0;
    int            act_sync_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends nbits of w on all lanes; the expectation is recorded as the last rise is driven.
    task automatic spi_word(input word_t w, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            int idx;
            idx = MSB ? (SZ - 1 - b) : b;
            for (int c = 0; c < CH; c++) spi_mosi[c] = w[c][idx];
            wait_clk($urandom_range(2, 4));
            spi_clk = 1'b1;
            if (b == SZ - 1) begin
                if (!u_if.data_ready && exp_q.size() > 0) begin
                    exp_q[exp_q.size()-1] = w;
                    exp_overrun = 1'b1;
                end else begin
                    exp_q.push_back(w);
                end
            end
            wait_clk($urandom_range(2, 4));
            spi_clk = 1'b0;
        end
    endtask

    task automatic ser_shift(input logic d);
        ser_data = d;
        wait_clk(2);
        ser_clk = 1'b1;
        col_model = {col_model[CB-2:0], d};
        wait_clk(2);
        ser_clk = 1'b0;
    endtask

    task automatic ser_latch();
        wait_clk(2);
        ser_stcp = 1'b1;
        col_q.push_back(col_model);
        wait_clk(2);
        ser_stcp = 1'b0;
    endtask

    task automatic ser_shift_latch(input logic d);
        ser_data = d;
        wait_clk(2);
        ser_clk  = 1'b1;
        ser_stcp = 1'b1;
        col_q.push_back(col_model);
        col_model = {col_model[CB-2:0], d};
        wait_clk(2);
        ser_clk  = 1'b0;
        ser_stcp = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 300;
        while ((exp_q.size() > 0 || col_q.size() > 0) && budget > 0) begin
            wait_clk(1);
            budget--;
        end
        if (budget == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: words left %0d, columns left %0d, required 0 and 0",
                     exp_q.size(), col_q.size());
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a word or a column latch.
    logic prev_se = 1'b0;
    always @(negedge clk) begin
        word_t w;
        logic [CB-1:0] cv;
        int exp_idx, ones;
        if (rst_n) begin
            if (u_if.data_valid && u_if.data_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, required no transfer",
                             u_if.data_out);
                end else begin
                    w = exp_q.pop_front();
                    chk("data_out", u_if.data_out, w);
                    chk("overrun_at_transfer", u_if.overrun, exp_overrun);
                end
            end
            if (u_if.sync_error) begin
                act_sync_err++;
                if (prev_se) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sync_error_width: got pulse > 1 cycle, required 1 cycle");
                end
            end
            prev_se = u_if.sync_error;
            if (column_valid) begin
                if (col_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_column: got 0x%0h, required no latch", column_out);
                end else begin
                    cv = col_q.pop_front();
                    exp_idx = 0;
                    ones = 0;
                    for (int i = 0; i < CB; i++) begin
                        if (cv[i]) ones++;
                    end
                    for (int i = CB - 1; i >= 0; i--) begin
                        if (cv[i]) exp_idx = i;
                    end
                    chk("column_out", column_out, cv);
                    chk("column_index", column_index, exp_idx);
                    chk("column_onehot", column_onehot, ones == 1);
                end
            end
        end else begin
            prev_se = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t w;
        u_if.data_ready = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);

        chk("reset_data_valid", u_if.data_valid, 0);
        chk("reset_data_out", u_if.data_out, 0);
        chk("reset_overrun", u_if.overrun, 0);
        chk("reset_column_out", column_out, 0);
        chk("reset_output_enabled", output_enabled, 0);

        ser_n_enable = 1'b0;
        wait_clk(6);
        chk("output_enabled_on", output_enabled, 1);

        // Fixed three-lane word.
        w[2] = 8'hA5;
        w[1] = 8'h3C;
        w[0] = 8'hFF;
        spi_word(w, SZ);
        drain();
        chk("overrun_after_first", u_if.overrun, 0);

        for (int k = 0; k < 20; k++) begin
            w = word_t'($urandom());
            spi_word(w, SZ);
        end
        drain();

        // Partial word aborted by inactivity, then a clean word.
        w = word_t'($urandom());
        spi_word(w, 5);
        exp_sync_err++;
        wait_clk(TO + 16);
        chk("sync_error_count", act_sync_err, exp_sync_err);
        w = word_t'($urandom());
        w[0] = 8'h81;
        spi_word(w, SZ);
        drain();

        // Back-to-back words with the consumer stalled.
        u_if.data_ready = 1'b0;
        w = word_t'($urandom());
        spi_word(w, SZ);
        w = word_t'($urandom());
        spi_word(w, SZ);
        wait_clk(8);
        chk("stalled_valid", u_if.data_valid, 1);
        chk("stalled_overrun", u_if.overrun, 1);
        chk("stalled_newest_word", u_if.data_out, w);
        u_if.data_ready = 1'b1;
        wait_clk(1);
        chk("valid_drop_after_transfer", u_if.data_valid, 0);
        chk("overrun_sticky", u_if.overrun, 1);
        drain();

        // Column path, with outputs disabled to show it still shifts and latches.
        ser_n_enable = 1'b1;
        ser_shift(1'b1);
        for (int k = 0; k < 15; k++) ser_shift(1'b0);
        ser_latch();
        drain();
        chk("column_8000", column_out, 16'h8000);
        chk("column_8000_index", column_index, 15);
        chk("output_enabled_off", output_enabled, 0);
        ser_shift(1'b0);
        ser_latch();
        drain();
        chk("column_zero_onehot", column_onehot, 0);
        ser_shift(1'b1);
        ser_shift_latch(1'b0);
        drain();
        chk("column_pre_shift", column_out, 16'h0001);
        ser_latch();
        for (int k = 0; k < 24; k++) begin
            ser_shift(1'($urandom()));
            if ($urandom_range(0, 3) == 0) ser_latch();
            if ($urandom_range(0, 7) == 0) ser_shift_latch(1'($urandom()));
        end
        drain();
        chk("sync_error_count_final", act_sync_err, exp_sync_err);

        // Reset in the middle of a word discards it.
        ser_n_enable = 1'b0;
        w = word_t'($urandom());
        spi_word(w, 4);
        rst_n = 1'b0;
        wait_clk(2);
        chk("midreset_data_valid", u_if.data_valid, 0);
        chk("midreset_data_out", u_if.data_out, 0);
        chk("midreset_overrun", u_if.overrun, 0);
        chk("midreset_sync_error", u_if.sync_error, 0);
        chk("midreset_column_out", column_out, 0);
        chk("midreset_column_valid", column_valid, 0);
        chk("midreset_column_onehot", column_onehot, 0);
        chk("midreset_output_enabled", output_enabled, 0);
        exp_q.delete();
        col_q.delete();
        col_model = '0;
        exp_overrun = 1'b0;
        rst_n = 1'b1;
        wait_clk(4);
        w = '0;
        for (int c = 0; c < CH; c++) w[c] = 8'h5A;
        spi_word(w, SZ);
        drain();
        chk("after_reset_overrun", u_if.overrun, 0);
        chk("after_reset_sync_error_count", act_sync_err, exp_sync_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
